// File: rtl/cam_trig_responder_pkg.sv
// rtl/cam_trig_responder_pkg.sv - shared state encoding and default sizing for the camera trigger responder
package cam_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2,
        READY   = 2'd3
    } cam_state_e;

    localparam int CW_DEF      = 24;
    localparam int RDY_LEN_DEF = 16;
    localparam int SEQ_LEN_DEF = 32;
    localparam int OVR_W_DEF   = 8;

endpackage

// File: rtl/cam_trig_responder_if.sv
// rtl/cam_trig_responder_if.sv - projector/camera trigger-ready handshake bundle
interface cam_trig_if;
    logic trig;
    logic f_frm;
    logic rdy;

    // projector side drives the trigger and first-frame flag, camera answers with rdy
    modport master (output trig, output f_frm, input rdy);
    modport slave  (input trig, input f_frm, output rdy);
endinterface

// File: rtl/cam_trig_responder_phase_timer.sv
// rtl/cam_trig_responder_phase_timer.sv - reloadable phase down-counter, load value clamped to at least 1
module cam_phase_timer #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= (load_val == '0) ? CW'(1) : load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // done marks the last cycle of the loaded phase
    assign done = (cnt_r == CW'(1));
    assign cnt  = cnt_r;

endmodule

// File: rtl/cam_trig_responder.sv
// rtl/cam_trig_responder.sv - camera-side trigger responder: exposure, readout, ready pulse, sequence tracking
module cam_trig_responder
    import cam_resp_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int RDY_LEN = RDY_LEN_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int OVR_W   = OVR_W_DEF,
    localparam int FW     = $clog2(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    cam_trig_if.slave        bus,
    input  logic [CW-1:0]    exp_cycles,
    input  logic [CW-1:0]    readout_cycles,
    output logic             busy,
    output logic             exposing,
    output logic [FW-1:0]    frame_idx,
    output logic             seq_done,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam logic [CW-1:0]    RDY_LEN_C = CW'(RDY_LEN);
    localparam logic [FW-1:0]    LAST_IDX  = FW'(SEQ_LEN - 1);
    localparam logic [OVR_W-1:0] OVR_MAX   = '1;

    cam_state_e    state;
    logic          trig_q;
    logic          trig_edge;
    logic          rdy_r;
    logic          first_pend;
    logic [CW-1:0] r_lat;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_done;

    assign trig_edge = bus.trig & ~trig_q;
    assign bus.rdy   = rdy_r;

    // one timer serves all three phases; it is reloaded on each phase entry
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = exp_cycles;
        if (mode) begin
            case (state)
                IDLE: begin
                    tmr_load = trig_edge;
                    tmr_val  = exp_cycles;
                end
                EXPOSE: begin
                    tmr_load = tmr_done;
                    tmr_val  = r_lat;
                end
                READOUT: begin
                    tmr_load = tmr_done;
                    tmr_val  = RDY_LEN_C;
                end
                default: begin
                    tmr_load = 1'b0;
                    tmr_val  = exp_cycles;
                end
            endcase
        end
    end

    cam_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (~mode),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            trig_q      <= 1'b1;
            rdy_r       <= 1'b0;
            busy        <= 1'b0;
            exposing    <= 1'b0;
            seq_done    <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            frame_idx   <= '0;
            first_pend  <= 1'b1;
            r_lat       <= CW'(1);
        end else begin
            trig_q   <= bus.trig;
            seq_done <= 1'b0;
            if (!mode) begin
                state      <= IDLE;
                rdy_r      <= 1'b0;
                exposing   <= 1'b0;
                busy       <= 1'b0;
                first_pend <= 1'b1;
            end else begin
                if (trig_edge && state != IDLE) begin
                    overrun <= 1'b1;
                    if (overrun_cnt != OVR_MAX)
                        overrun_cnt <= overrun_cnt + OVR_W'(1);
                end
                case (state)
                    IDLE: begin
                        if (trig_edge) begin
                            state      <= EXPOSE;
                            busy       <= 1'b1;
                            exposing   <= 1'b1;
                            first_pend <= 1'b0;
                            r_lat      <= (readout_cycles == '0) ? CW'(1) : readout_cycles;
                            if (first_pend || bus.f_frm)
                                frame_idx <= '0;
                            else if (frame_idx == LAST_IDX)
                                frame_idx <= '0;
                            else
                                frame_idx <= frame_idx + FW'(1);
                        end
                    end
                    EXPOSE: begin
                        if (tmr_done) begin
                            state    <= READOUT;
                            exposing <= 1'b0;
                            // a one-cycle readout makes the next cycle the final one
                            if (frame_idx == LAST_IDX && r_lat == CW'(1))
                                seq_done <= 1'b1;
                        end
                    end
                    READOUT: begin
                        if (frame_idx == LAST_IDX && tmr_cnt == CW'(2))
                            seq_done <= 1'b1;
                        if (tmr_done) begin
                            state <= READY;
                            rdy_r <= 1'b1;
                        end
                    end
                    READY: begin
                        if (tmr_done) begin
                            state <= IDLE;
                            rdy_r <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_trig_responder.sv
// tb/tb_cam_trig_responder.sv - scoreboard bench for cam_trig_responder
module tb_cam_trig_responder;

    localparam int CW      = 24;
    localparam int RDY_LEN = 4;
    localparam int SEQ_LEN = 32;
    localparam int OVR_W   = 8;

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [CW-1:0]    exp_cycles;
    logic [CW-1:0]    readout_cycles;
    logic             busy;
    logic             exposing;
    logic [4:0]       frame_idx;
    logic             seq_done;
    logic             overrun;
    logic [OVR_W-1:0] overrun_cnt;

    cam_trig_if bus ();

    cam_trig_responder #(
        .CW(CW), .RDY_LEN(RDY_LEN), .SEQ_LEN(SEQ_LEN), .OVR_W(OVR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .bus            (bus),
        .exp_cycles     (exp_cycles),
        .readout_cycles (readout_cycles),
        .busy           (busy),
        .exposing       (exposing),
        .frame_idx      (frame_idx),
        .seq_done       (seq_done),
        .overrun        (overrun),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   seq_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // start a frame in the current cycle and queue its expected ready pulse
    task automatic fire(input int n, input bit f, input int e, input int r, input int idx);
        goto_cyc(n);
        bus.f_frm      = f;
        exp_cycles     = CW'(e);
        readout_cycles = CW'(r);
        bus.trig       = 1'b1;
        exp_q.push_back('{n + 1 + ((e < 1) ? 1 : e) + ((r < 1) ? 1 : r), idx});
    endtask

    // scoreboard monitor
    bit rdy_prev = 1'b0;
    int rdy_len  = 0;
    always @(negedge clk) begin
        if (bus.rdy === 1'b1 && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdy_unexpected: got rise at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdy_rise_cycle", cyc, e.cyc);
                chk("rdy_frame_idx", frame_idx, e.idx);
            end
        end
        if (bus.rdy === 1'b1) rdy_len++;
        if (bus.rdy !== 1'b1 && rdy_prev) begin
            chk("rdy_width", rdy_len, RDY_LEN);
            rdy_len = 0;
        end
        rdy_prev = (bus.rdy === 1'b1);

        if (seq_done !== 1'b0) begin
            if (seq_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL seq_done_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                chk("seq_done_cycle", cyc, seq_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mode           = 1'b1;
        bus.trig       = 1'b0;
        bus.f_frm      = 1'b0;
        exp_cycles     = 24'd10;
        readout_cycles = 24'd5;

        goto_cyc(2);
        @(negedge clk);
        chk("rst_rdy", bus.rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_exposing", exposing, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_cnt", overrun_cnt, 0);
        chk("rst_frame_idx", frame_idx, 0);
        goto_cyc(5);
        rst = 1'b0;

        // nominal frame; length changes mid-frame must not matter
        fire(100, 1'b0, 10, 5, 0);
        for (int c = 100; c <= 121; c++) begin
            goto_cyc(c);
            if (c == 105) begin
                exp_cycles     = 24'd3;
                readout_cycles = 24'd50;
            end
            @(negedge clk);
            chk("nom_exposing", exposing, (c >= 101 && c <= 110));
            chk("nom_busy", busy, (c >= 101 && c <= 119));
        end
        goto_cyc(130);
        bus.trig = 1'b0;

        // overrun during readout, then an accepted edge once idle
        fire(200, 1'b0, 10, 5, 1);
        goto_cyc(205);
        bus.trig = 1'b0;
        goto_cyc(212);
        bus.trig = 1'b1;
        goto_cyc(213);
        @(negedge clk);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt_1", overrun_cnt, 1);
        goto_cyc(220);
        bus.trig = 1'b0;
        fire(225, 1'b0, 10, 5, 2);
        goto_cyc(230);
        bus.trig = 1'b0;

        // edge on the last READY cycle is an overrun
        fire(300, 1'b0, 10, 5, 3);
        goto_cyc(301);
        bus.trig = 1'b0;
        goto_cyc(319);
        bus.trig = 1'b1;
        goto_cyc(321);
        @(negedge clk);
        chk("ovr_cnt_ready_edge", overrun_cnt, 2);
        chk("ready_edge_idle", busy, 0);
        goto_cyc(325);
        bus.trig = 1'b0;

        // zero lengths clamp to one cycle each
        fire(400, 1'b0, 0, 0, 4);
        goto_cyc(401);
        @(negedge clk);
        chk("zero_exposing_n1", exposing, 1);
        goto_cyc(402);
        bus.trig = 1'b0;
        @(negedge clk);
        chk("zero_exposing_n2", exposing, 0);

        // full scan with wrap
        for (int i = 0; i < 32; i++) begin
            fire(500 + 10 * i, (i == 0), 2, 1, i);
            if (i == 31) seq_q.push_back(500 + 10 * i + 3);
            goto_cyc(501 + 10 * i);
            bus.trig = 1'b0;
        end
        fire(820, 1'b1, 2, 1, 0);
        goto_cyc(821);
        bus.trig = 1'b0;
        fire(830, 1'b0, 2, 1, 1);
        goto_cyc(831);
        bus.trig = 1'b0;

        // mode abort mid-exposure
        fire(900, 1'b0, 10, 5, 2);
        void'(exp_q.pop_back());
        goto_cyc(901);
        bus.trig = 1'b0;
        goto_cyc(905);
        mode = 1'b0;
        @(negedge clk);
        chk("abort_busy_n5", busy, 1);
        goto_cyc(906);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_exposing", exposing, 0);
        chk("abort_frame_idx", frame_idx, 2);
        goto_cyc(907);
        bus.trig = 1'b1;
        goto_cyc(908);
        bus.trig = 1'b0;
        goto_cyc(909);
        @(negedge clk);
        chk("mode0_edge_not_counted", overrun_cnt, 2);
        chk("mode0_idle", busy, 0);
        goto_cyc(910);
        mode = 1'b1;
        fire(920, 1'b0, 1, 1, 0);
        goto_cyc(921);
        bus.trig = 1'b0;

        // trig held high across reset release
        goto_cyc(1000);
        rst      = 1'b1;
        bus.trig = 1'b1;
        goto_cyc(1002);
        @(negedge clk);
        chk("rst2_overrun", overrun, 0);
        chk("rst2_overrun_cnt", overrun_cnt, 0);
        chk("rst2_frame_idx", frame_idx, 0);
        goto_cyc(1005);
        rst = 1'b0;
        for (int c = 1006; c <= 1010; c++) begin
            goto_cyc(c);
            @(negedge clk);
            chk("held_trig_no_start", busy, 0);
        end
        bus.trig = 1'b0;
        fire(1012, 1'b0, 1, 1, 0);
        goto_cyc(1020);
        bus.trig = 1'b0;

        // overrun counter saturation
        fire(1100, 1'b0, 10000, 1, 1);
        goto_cyc(1101);
        bus.trig = 1'b0;
        for (int k = 0; k < 300; k++) begin
            goto_cyc(1102 + 2 * k);
            bus.trig = 1'b1;
            tick();
            bus.trig = 1'b0;
        end
        goto_cyc(1702);
        @(negedge clk);
        chk("ovr_cnt_saturated", overrun_cnt, 255);
        chk("ovr_flag_sat", overrun, 1);
        chk("sat_still_exposing", exposing, 1);

        goto_cyc(11115);
        @(negedge clk);
        chk("rdy_queue_drained", exp_q.size(), 0);
        chk("seq_queue_drained", seq_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
